// File: rtl/uart_rx_frame_receiver.sv
// rtl/uart_rx_frame_receiver.sv - UART receive engine: oversampled start detect, 3-sample majority, LSB-first deserializer, parity/stop check.
// Optional RX_INPUT_SYNC_EN: 2-flop synchronizer on RX_IN (reset to 1) ahead of all logic.
module uart_rx_frame_receiver #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESC_W-1:0]    PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state, next_state;

    logic                  rx;
    logic [PRESC_W-1:0]    presc_legal;
    logic [PRESC_W-1:0]    presc_q;
    logic [PRESC_W-1:0]    half;
    logic [PRESC_W-1:0]    edge_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [2:0]            samples;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  bit_end;
    logic                  sample_act;
    logic                  maj;
    logic                  exp_par;
    logic                  start_glitch;

`ifdef RX_INPUT_SYNC_EN
    logic [1:0] rx_sync;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], RX_IN};
        end
    end

    assign rx = rx_sync[1];
`else
    assign rx = RX_IN;
`endif

    // Anything other than 16 or 32 falls back to 8x oversampling.
    always_comb begin
        presc_legal = PRESC_W'(8);
        if (PRESCALE == PRESC_W'(16) || PRESCALE == PRESC_W'(32)) begin
            presc_legal = PRESCALE;
        end
    end

    assign half         = presc_q >> 1;
    assign bit_end      = (edge_cnt == presc_q - PRESC_W'(1));
    assign sample_act   = (edge_cnt == half + PRESC_W'(1));
    assign maj          = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                          (samples[1] & samples[2]);
    assign exp_par      = par_typ_q ? ~^shift_reg : ^shift_reg;
    assign start_glitch = (state == START) && sample_act && maj;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!rx) next_state = START;
            end
            START: begin
                if (start_glitch)  next_state = IDLE;
                else if (bit_end)  next_state = DATA;
            end
            DATA: begin
                if (bit_end && bit_cnt == LAST_BIT) next_state = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end) next_state = STOP;
            end
            STOP: begin
                if (bit_end) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            presc_q    <= PRESC_W'(8);
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            samples    <= 3'b111;
            shift_reg  <= '0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            if (state == IDLE) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
                if (!rx) begin
                    presc_q   <= presc_legal;
                    par_en_q  <= PAR_EN;
                    par_typ_q <= PAR_TYP;
                    PAR_ERR   <= 1'b0;
                    STP_ERR   <= 1'b0;
                end
            end else begin
                edge_cnt <= bit_end ? '0 : edge_cnt + PRESC_W'(1);
                if (edge_cnt == half - PRESC_W'(2)) samples[0] <= rx;
                if (edge_cnt == half - PRESC_W'(1)) samples[1] <= rx;
                if (edge_cnt == half)               samples[2] <= rx;

                if (state == DATA && bit_end) begin
                    bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_W'(1);
                end

                // Majority decision lands two cycles after the middle sample.
                if (sample_act) begin
                    case (state)
                        DATA:    shift_reg <= {maj, shift_reg[DATA_WIDTH-1:1]};
                        PARITY:  if (maj != exp_par) PAR_ERR <= 1'b1;
                        STOP:    if (!maj) STP_ERR <= 1'b1;
                        default: ;
                    endcase
                end

                if (state == STOP && bit_end && !PAR_ERR && !STP_ERR) begin
                    P_DATA     <= shift_reg;
                    DATA_VALID <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_receiver.sv
// tb/tb_uart_rx_frame_receiver.sv - directed table-driven bench for uart_rx_frame_receiver.
module tb_uart_rx_frame_receiver;

    localparam int DW = 8;
    localparam int PW = 6;
`ifdef RX_INPUT_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] PRESCALE = 6'd8;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_ERR;
    logic          STP_ERR;

    uart_rx_frame_receiver #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PRESCALE   (PRESCALE),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    always #5 CLK = ~CLK;

    int            cyc = 0;
    int            strobe_cnt = 0;
    int            last_strobe_cyc = 0;
    logic [DW-1:0] strobe_q[$];
    int            n_checks = 0;
    int            n_fail = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (DATA_VALID === 1'b1) begin
            strobe_cnt      <= strobe_cnt + 1;
            last_strobe_cyc <= cyc;
            strobe_q.push_back(P_DATA);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Bits go out P cycles each; cycle c of a bit is sampled by edge t0 + b*P + c.
    task automatic send_frame(input int p, input logic [7:0] d, input logic pe, input logic pb,
                              input logic sb, input int gb, input int gc, input int max_bits,
                              input logic scr, output int t0, output logic [1:0] mid);
        logic [10:0] bits;
        int nb;
        bits    = '1;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[k+1] = d[k];
        if (pe) begin
            bits[9]  = pb;
            bits[10] = sb;
            nb       = 11;
        end else begin
            bits[9] = sb;
            nb      = 10;
        end
        if (max_bits < nb) nb = max_bits;
        t0  = cyc + 1;
        mid = 2'b00;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < p; c++) begin
                if (b == 1 && c == 0) begin
                    mid = {PAR_ERR, STP_ERR};
                    if (scr) begin
                        PRESCALE = ~PRESCALE;
                        PAR_EN   = ~PAR_EN;
                        PAR_TYP  = ~PAR_TYP;
                    end
                end
                RX_IN = (b == gb && c == gc) ? ~bits[b] : bits[b];
                @(posedge CLK);
                #1;
            end
        end
    endtask

    typedef struct {
        int            p;
        logic [PW-1:0] cfg;
        logic          par_en;
        logic          par_typ;
        logic [7:0]    data;
        logic          par_bit;
        logic          stop_bit;
        int            gl_bit;
        int            gl_cyc;
        int            exp_cnt;
        logic [7:0]    exp_data;
        logic          exp_pe;
        logic          exp_se;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    initial begin
        int         t0;
        int         base;
        int         qbase;
        logic [1:0] mid;

        vecs[0] = '{8,  6'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, -1, 0, 1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{16, 6'd16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, -1, 0, 1, 8'h3C, 1'b0, 1'b0};
        vecs[2] = '{16, 6'd16, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, -1, 0, 1, 8'h3C, 1'b0, 1'b0};
        vecs[3] = '{32, 6'd32, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, -1, 0, 1, 8'hC3, 1'b0, 1'b0};
        vecs[4] = '{16, 6'd16, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, -1, 0, 0, 8'hC3, 1'b1, 1'b0};
        vecs[5] = '{8,  6'd8,  1'b0, 1'b0, 8'h55, 1'b0, 1'b0, -1, 0, 0, 8'hC3, 1'b0, 1'b1};
        vecs[6] = '{8,  6'd8,  1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, -1, 0, 1, 8'h0F, 1'b0, 1'b0};
        vecs[7] = '{8,  6'd12, 1'b0, 1'b0, 8'h6A, 1'b0, 1'b1, -1, 0, 1, 8'h6A, 1'b0, 1'b0};
        vecs[8] = '{8,  6'd8,  1'b1, 1'b0, 8'h07, 1'b1, 1'b1,  9, 4, 1, 8'h07, 1'b0, 1'b0};
        vecs[9] = '{16, 6'd16, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1,  4, 8, 1, 8'h5A, 1'b0, 1'b0};

        RST   = 1'b0;
        RX_IN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_p_data", 32'(P_DATA), 32'h0);
        check("reset_valid", 32'(DATA_VALID), 32'h0);
        check("reset_par_err", 32'(PAR_ERR), 32'h0);
        check("reset_stp_err", 32'(STP_ERR), 32'h0);
        RST = 1'b1;
        idle(5);

        for (int i = 0; i < NV; i++) begin
            PRESCALE = vecs[i].cfg;
            PAR_EN   = vecs[i].par_en;
            PAR_TYP  = vecs[i].par_typ;
            base     = strobe_cnt;
            send_frame(vecs[i].p, vecs[i].data, vecs[i].par_en, vecs[i].par_bit,
                       vecs[i].stop_bit, vecs[i].gl_bit, vecs[i].gl_cyc, 99, 1'b1, t0, mid);
            idle(3 * vecs[i].p);
            check($sformatf("v%0d_strobes", i), 32'(strobe_cnt - base), 32'(vecs[i].exp_cnt));
            check($sformatf("v%0d_p_data", i), 32'(P_DATA), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_par_err", i), 32'(PAR_ERR), 32'(vecs[i].exp_pe));
            check($sformatf("v%0d_stp_err", i), 32'(STP_ERR), 32'(vecs[i].exp_se));
            check($sformatf("v%0d_flags_cleared", i), 32'(mid), 32'h0);
            if (strobe_cnt - base == 1) begin
                check($sformatf("v%0d_latency", i), 32'(last_strobe_cyc - t0),
                      32'((10 + int'(vecs[i].par_en)) * vecs[i].p + SYNC));
            end
        end

        // Three-cycle low pulse is rejected as a false start.
        PRESCALE = 6'd16;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        base     = strobe_cnt;
        RX_IN    = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        idle(40);
        check("glitch_strobes", 32'(strobe_cnt - base), 32'h0);
        check("glitch_par_err", 32'(PAR_ERR), 32'h0);
        check("glitch_stp_err", 32'(STP_ERR), 32'h0);
        check("glitch_p_data", 32'(P_DATA), 32'h5A);

        // Line stuck low: stop error, then immediate re-detect clears the flag.
        PRESCALE = 6'd8;
        base     = strobe_cnt;
        send_frame(8, 8'h00, 1'b0, 1'b0, 1'b0, -1, 0, 99, 1'b0, t0, mid);
        RX_IN = 1'b0;
        repeat (1 + SYNC) @(posedge CLK);
        #1;
        check("stuck_low_stp_err", 32'(STP_ERR), 32'h1);
        @(posedge CLK);
        #1;
        check("stuck_low_restart", 32'(STP_ERR), 32'h0);
        idle(40);
        check("stuck_low_strobes", 32'(strobe_cnt - base), 32'h0);
        check("stuck_low_p_data", 32'(P_DATA), 32'h5A);

        // Reset in the middle of frame 0x81.
        base = strobe_cnt;
        send_frame(8, 8'h81, 1'b0, 1'b0, 1'b1, -1, 0, 4, 1'b0, t0, mid);
        RST = 1'b0;
        #2;
        check("rst_mid_outputs", {23'h0, P_DATA, DATA_VALID}, 32'h0);
        check("rst_mid_flags", {30'h0, PAR_ERR, STP_ERR}, 32'h0);
        RX_IN = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        idle(16);
        send_frame(8, 8'h7E, 1'b0, 1'b0, 1'b1, -1, 0, 99, 1'b0, t0, mid);
        idle(24);
        check("after_rst_strobes", 32'(strobe_cnt - base), 32'h1);
        check("after_rst_p_data", 32'(P_DATA), 32'h7E);

        // Back-to-back frames with no idle gap.
        base  = strobe_cnt;
        qbase = strobe_q.size();
        send_frame(8, 8'h01, 1'b0, 1'b0, 1'b1, -1, 0, 99, 1'b0, t0, mid);
        send_frame(8, 8'h02, 1'b0, 1'b0, 1'b1, -1, 0, 99, 1'b0, t0, mid);
        idle(24);
        check("b2b_strobes", 32'(strobe_cnt - base), 32'h2);
        if (strobe_q.size() >= qbase + 2) begin
            check("b2b_first", 32'(strobe_q[qbase]), 32'h01);
            check("b2b_second", 32'(strobe_q[qbase+1]), 32'h02);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL b2b_values: got %0d strobes expected 2", strobe_q.size() - qbase);
        end
        check("b2b_p_data", 32'(P_DATA), 32'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_receiver.md
Name: uart_rx_frame_receiver

Overview:
- UART receive engine: the receive-side counterpart of the TX path.
- Oversamples RX_IN, detects start, majority-samples each bit, deserializes LSB-first, checks parity and stop, presents a byte with a one-cycle valid strobe.
- Sits in the UART block on the UART clock domain; its output feeds the RX-to-system data synchronizer.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- PRESC_W, 6, width of PRESCALE input.

Ports:
- CLK  in  1  UART oversampling clock
- RST  in  1  reset
- RX_IN  in  1  serial line, idle high
- PRESCALE  in  PRESC_W  oversampling ratio; legal 8, 16, 32
- PAR_EN  in  1  1 = frame carries parity bit
- PAR_TYP  in  1  0 = even, 1 = odd
- P_DATA  out  DATA_WIDTH  last good received byte
- DATA_VALID  out  1  one-cycle strobe, P_DATA new
- PAR_ERR  out  1  parity error of last frame
- STP_ERR  out  1  stop-bit error of last frame

Behaviour:
- Reset: RST asynchronous, active-low; clock CLK. All outputs 0; FSM in IDLE; counters 0. Reset mid-frame aborts the frame with no strobe.
- Config latch:
  - PRESCALE, PAR_EN and PAR_TYP are captured on start detection; mid-frame changes are ignored.
  - An illegal PRESCALE value is treated as 8.
- Counters:
  - edge_cnt runs 0..P-1 per bit and wraps to 0 at each bit boundary.
  - bit_cnt runs 0..DATA_WIDTH-1 in DATA.
- Sampling:
  - Samples are taken at edge_cnt = P/2-2, P/2-1 and P/2.
  - Bit value = majority of the 3 samples, registered at edge_cnt = P/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: stay while RX_IN = 1. RX_IN = 0 -> START, edge_cnt = 0 on that edge; PAR_ERR and STP_ERR cleared.
  - START: if the majority start bit = 1 (glitch) -> IDLE at sample point; no outputs change. Else at edge_cnt = P-1 -> DATA.
  - DATA: sampled bit shifts into shift_reg LSB-first (bit 0 = first data bit). At edge_cnt = P-1 with bit_cnt = DATA_WIDTH-1 -> PARITY if PAR_EN, else STOP.
  - PARITY: expected = ^shift_reg for even, ~^shift_reg for odd. Mismatch sets PAR_ERR at the sample point. At edge_cnt = P-1 -> STOP.
  - STOP: sampled 0 sets STP_ERR. At edge_cnt = P-1 -> IDLE.
- Frame end (last edge of stop bit):
  - If PAR_ERR = 0 and STP_ERR = 0: P_DATA <= shift_reg and DATA_VALID = 1 for exactly one cycle.
  - Otherwise P_DATA is held and there is no strobe.
  - Error flags hold until the next start detection.
- Latency: DATA_VALID is visible (10 or 11) × P cycles after the first CLK edge sampling RX_IN = 0, plus synchronizer delay if enabled.
- Back-to-back frames: IDLE re-detects a low line on the cycle after STOP. A 1-cycle slip per frame is acceptable.
- RX_IN held low continuously: frame completes with STP_ERR = 1. FSM then restarts, producing repeated STP_ERR frames until the line goes high.

Optional Feature:
- Macro: RX_INPUT_SYNC_EN.
- Defined: RX_IN passes through a 2-flop synchronizer (reset to 1) before all logic. Adds 2 cycles to all latencies.
- Undefined: RX_IN is used directly and must already be synchronous to CLK.

Test Plan:
- PRESCALE = 8, PAR_EN = 0, send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first), stop = 1 -> one DATA_VALID pulse, P_DATA = 0xA5 at 80 cycles (+1); PAR_ERR = STP_ERR = 0.
- PRESCALE = 16, PAR_EN = 1, PAR_TYP = 0, send 0x3C with parity 0 -> DATA_VALID, P_DATA = 0x3C at 176 cycles. Repeat with PAR_TYP = 1 and parity 1 -> same result.
- PAR_EN = 1, PAR_TYP = 1, send 0x3C with parity 0 (wrong) -> PAR_ERR = 1, no DATA_VALID, P_DATA keeps prior value 0x3C/0xA5.
- Send 0x55 with stop bit 0 -> STP_ERR = 1, no strobe. Next clean frame 0x0F -> flags clear at its start, DATA_VALID, P_DATA = 0x0F.
- PRESCALE = 16, RX_IN low for 3 cycles then high -> FSM returns to IDLE; no flags, no strobe. Single-cycle low glitch inside a data bit -> majority vote keeps the correct value.
- Assert RST during DATA of frame 0x81 -> outputs 0, IDLE. Following frame 0x7E received correctly. Back-to-back frames 0x01, 0x02 with no idle gap -> two strobes, values in order.
